// File: rtl/instruct_loader.sv
// Instruction RAM loader: assembles a little-endian byte stream into 32-bit words
// and issues one word-aligned write per word, starting at a checked base address.
module instruct_loader #(
  parameter int MEM_SIZE = 1024,
  parameter int LEN_W    = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [63:0]      base_addr,
  input  logic [LEN_W-1:0] word_count,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic             in_ready,
  output logic             wr_en,
  output logic [63:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERR} state_t;

  state_t           state;
  logic [63:0]      addr;
  logic [LEN_W-1:0] remaining;
  logic [1:0]       idx;
  logic [23:0]      word;
  logic             wr_pend;
  logic [65:0]      end_addr;
  logic             bad_start;

  // Two guard bits keep the range check exact even for base addresses near 2^64.
  assign end_addr  = {2'b00, base_addr} + (66'(word_count) << 2);
  assign bad_start = (base_addr[1:0] != 2'b00) || (end_addr > 66'(MEM_SIZE));

  // An abort during the write cycle suppresses the strobe in that same cycle.
  assign wr_en = wr_pend & ~abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      idx       <= '0;
      word      <= '0;
      wr_pend   <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            done  <= 1'b0;
            error <= 1'b0;
            if (bad_start) begin
              state <= ERR;
              error <= 1'b1;
            end else if (word_count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= LOAD;
              addr      <= base_addr;
              remaining <= word_count;
              idx       <= '0;
              in_ready  <= 1'b1;
              busy      <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (abort) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end else if (in_valid) begin
            idx <= idx + 2'd1;
            case (idx)
              2'd0: word[7:0]   <= in_byte;
              2'd1: word[15:8]  <= in_byte;
              2'd2: word[23:16] <= in_byte;
              default: begin
                state    <= WRITE;
                in_ready <= 1'b0;
                wr_pend  <= 1'b1;
                wr_addr  <= addr;
                wr_data  <= {in_byte, word};
              end
            endcase
          end
        end
        WRITE: begin
          wr_pend <= 1'b0;
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            addr      <= addr + 64'd4;
            remaining <= remaining - 1'b1;
            idx       <= '0;
            if (remaining == LEN_W'(1)) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state    <= LOAD;
              in_ready <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruct_loader.sv
// Directed bench for instruct_loader: load, alignment/range errors, gaps, abort,
// asynchronous reset, zero-length loads and start-while-busy.
module tb_instruct_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] base_addr;
  logic [8:0]  word_count;
  logic        abort;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        wr_en;
  logic [63:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;

  int vectors = 0;
  int miscompares = 0;
  logic [95:0] wq[$];

  instruct_loader #(.MEM_SIZE(1024), .LEN_W(9)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .abort(abort), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Write log, sampled mid-cycle.
  always @(negedge clk) if (wr_en) wq.push_back({wr_addr, wr_data});

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [63:0] b, input logic [8:0] n);
    start = 1'b1; base_addr = b; word_count = n;
    cyc();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1; in_byte = b;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk); acc = in_ready;
      cyc();
    end
    in_valid = 1'b0;
    vectors++;
    if (acc !== 1'b1) begin
      miscompares++;
      $display("FAIL send_byte_timeout byte=%h in_ready never seen, required 1", b);
    end
  endtask

  task automatic check_write(input string name, input int k, input logic [63:0] a, input logic [31:0] d);
    vectors++;
    if (wq.size() <= k) begin
      miscompares++;
      $display("FAIL %s write %0d missing, got %0d writes", name, k, wq.size());
    end else if (wq[k] !== {a, d}) begin
      miscompares++;
      $display("FAIL %s write %0d got (%h,%h) required (%h,%h)", name, k, wq[k][95:32], wq[k][31:0], a, d);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({in_ready, wr_en, busy, done, error, wr_addr, wr_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got rdy=%b we=%b busy=%b done=%b err=%b addr=%h data=%h required all 0",
               in_ready, wr_en, busy, done, error, wr_addr, wr_data);
    end
  endtask

  task automatic test_basic();
    wq.delete();
    do_start(64'd0, 9'd2);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h91);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    cyc(); cyc();
    @(negedge clk);
    vectors++;
    if (wq.size() !== 2) begin
      miscompares++; $display("FAIL basic_count got %0d required 2", wq.size());
    end
    check_write("basic", 0, 64'd0, 32'h91000013);
    check_write("basic", 1, 64'd4, 32'h12345678);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL basic_status done=%b busy=%b required 1/0", done, busy);
    end
  endtask

  task automatic test_misaligned();
    wq.delete();
    do_start(64'd2, 9'd1);
    @(negedge clk);
    vectors++;
    if (error !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL misaligned error=%b rdy=%b busy=%b required 1/0/0", error, in_ready, busy);
    end
    cyc(); cyc(); cyc();
    vectors++;
    if (wq.size() !== 0) begin
      miscompares++; $display("FAIL misaligned_writes got %0d required 0", wq.size());
    end
    do_start(64'd0, 9'd1);
    @(negedge clk);
    vectors++;
    if (error !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL error_clear error=%b busy=%b rdy=%b required 0/1/1", error, busy, in_ready);
    end
    abort = 1'b1; cyc(); abort = 1'b0;
  endtask

  task automatic test_range();
    wq.delete();
    do_start(64'd1016, 9'd3);
    @(negedge clk);
    vectors++;
    if (error !== 1'b1) begin
      miscompares++; $display("FAIL range_over error got %b required 1", error);
    end
    cyc();
    do_start(64'd1020, 9'd1);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    @(negedge clk);
    vectors++;
    if (wr_en !== 1'b1 || wr_addr !== 64'd1020 || wr_data !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL range_last_latency we=%b addr=%h data=%h required 1/3fc/deadbeef", wr_en, wr_addr, wr_data);
    end
    cyc(); cyc();
    @(negedge clk);
    check_write("range_last", 0, 64'd1020, 32'hDEADBEEF);
    vectors++;
    if (done !== 1'b1 || error !== 1'b0 || wq.size() !== 1) begin
      miscompares++; $display("FAIL range_last_status done=%b err=%b writes=%0d required 1/0/1", done, error, wq.size());
    end
  endtask

  task automatic test_gaps_abort();
    logic [7:0] img [8];
    img = '{8'h13, 8'h00, 8'h00, 8'h91, 8'h78, 8'h56, 8'h34, 8'h12};
    wq.delete();
    do_start(64'd0, 9'd2);
    for (int i = 0; i < 8; i++) begin
      send_byte(img[i]);
      cyc();
    end
    cyc(); cyc();
    @(negedge clk);
    check_write("gaps", 0, 64'd0, 32'h91000013);
    check_write("gaps", 1, 64'd4, 32'h12345678);
    vectors++;
    if (done !== 1'b1 || wq.size() !== 2) begin
      miscompares++; $display("FAIL gaps_status done=%b writes=%0d required 1/2", done, wq.size());
    end
    wq.delete();
    do_start(64'd0, 9'd2);
    for (int i = 0; i < 6; i++) send_byte(img[i]);
    abort = 1'b1; cyc(); abort = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    check_write("abort", 0, 64'd0, 32'h91000013);
    vectors++;
    if (wq.size() !== 1 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++; $display("FAIL abort_status writes=%0d busy=%b done=%b rdy=%b required 1/0/0/0",
                              wq.size(), busy, done, in_ready);
    end
  endtask

  task automatic test_async_reset();
    do_start(64'd0, 9'd2);
    send_byte(8'hAA); send_byte(8'hBB);
    reset = 1'b0;
    #2;
    vectors++;
    if ({in_ready, wr_en, busy, done, error, wr_addr, wr_data} !== '0) begin
      miscompares++;
      $display("FAIL async_reset got rdy=%b we=%b busy=%b done=%b err=%b addr=%h data=%h required all 0",
               in_ready, wr_en, busy, done, error, wr_addr, wr_data);
    end
    cyc();
    reset = 1'b1;
    cyc();
    test_basic();
  endtask

  task automatic test_zero_and_busy_start();
    wq.delete();
    do_start(64'd8, 9'd0);
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL zero_count done=%b busy=%b required 1/0", done, busy);
    end
    cyc(); cyc();
    do_start(64'd16, 9'd1);
    send_byte(8'h01);
    do_start(64'd32, 9'd2);
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    cyc(); cyc();
    @(negedge clk);
    check_write("busy_start", 0, 64'd16, 32'h04030201);
    vectors++;
    if (wq.size() !== 1 || done !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL busy_start_status writes=%0d done=%b busy=%b required 1/1/0", wq.size(), done, busy);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    abort = 1'b0; in_valid = 1'b0; in_byte = '0;
    #12;
    test_reset();
    #3 reset = 1'b1;
    cyc();
    test_basic();
    test_misaligned();
    test_range();
    test_gaps_abort();
    test_async_reset();
    test_zero_and_busy_start();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
